// File: rtl/quadrature_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_decoder_if
// Description : Encoder inputs, control and status bundle of the quadrature decoder.
// Revision    : 1.0
// ============================================================================
interface quadrature_decoder_if #(
  parameter int EW = 8
);
  logic          enc_a;
  logic          enc_b;
  logic          en;
  logic          clr_err;
  logic [1:0]    control;
  logic          err;
  logic [EW-1:0] err_count;
  logic          ready;

  modport master (
    output enc_a, enc_b, en, clr_err,
    input  control, err, err_count, ready
  );

  modport slave (
    input  enc_a, enc_b, en, clr_err,
    output control, err, err_count, ready
  );
endinterface
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_decoder
// Description : Synchronised, debounced quadrature decoder emitting INC/DEC steps.
// Revision    : 1.0
// ============================================================================
module quadrature_decoder #(
  parameter int DB_CYCLES = 4,
  parameter int EW        = 8
) (
  input  logic               clk,
  input  logic               rst,
  quadrature_decoder_if.slave bus
);

  localparam logic [0:0]    c_ST_INIT    = 1'b0;
  localparam logic [0:0]    c_ST_TRACK   = 1'b1;
  localparam logic [7:0]    c_DB_LAST    = 8'(DB_CYCLES - 1);
  localparam logic [8:0]    c_INIT_LAST  = 9'(DB_CYCLES + 1);
  localparam logic [EW-1:0] c_ERR_MAX    = '1;
  localparam logic [1:0]    c_CTRL_HOLD  = 2'b00;
  localparam logic [1:0]    c_CTRL_INC   = 2'b01;
  localparam logic [1:0]    c_CTRL_DEC   = 2'b10;

  logic [0:0]    r_state;
  logic [8:0]    r_init_cnt;
  logic          r_ready;
  logic [1:0]    r_prev;
  logic [1:0]    r_control;
  logic          r_err;
  logic [EW-1:0] r_err_count;

  logic          w_init;
  logic [1:0]    w_enc;
  logic [1:0]    w_s2;
  logic [1:0]    w_filt;
  logic [1:0]    w_step;
  logic          w_illegal;

  assign w_init = (r_state == c_ST_INIT);
  assign w_enc  = {bus.enc_a, bus.enc_b};

  // Bit 1 is channel A, bit 0 is channel B; each channel is synchronised and
  // debounced on its own so both may settle in the same cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic       r_s1;
    logic       r_s2;
    logic       r_filt;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_filt <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1 <= w_enc[gi];
        r_s2 <= r_s1;
        if (w_init) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
        end else if (r_s2 == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end

    assign w_s2[gi]   = r_s2;
    assign w_filt[gi] = r_filt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          if (r_init_cnt == c_INIT_LAST) begin
            r_state <= c_ST_TRACK;
            r_ready <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + 9'd1;
          end
        end
        default: begin
          r_state <= c_ST_TRACK;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // During INIT prev follows the raw synchronised level so TRACK starts with cur == prev.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 2'b00;
    end else if (w_init) begin
      r_prev <= w_s2;
    end else begin
      r_prev <= w_filt;
    end
  end

  always_comb begin
    w_step    = c_CTRL_HOLD;
    w_illegal = 1'b0;
    if (!w_init) begin
      case ({r_prev, w_filt})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_step    = c_CTRL_INC;
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_step    = c_CTRL_DEC;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
        default:                                w_step    = c_CTRL_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_control   <= c_CTRL_HOLD;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_control <= bus.en ? w_step : c_CTRL_HOLD;
      r_err     <= bus.en & w_illegal;
      if (bus.clr_err) begin
        r_err_count <= '0;
      end else if (w_illegal && (r_err_count != c_ERR_MAX)) begin
        r_err_count <= r_err_count + EW'(1);
      end
    end
  end

  assign bus.control   = r_control;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.ready     = r_ready;

endmodule
`default_nettype wire
